pgr_apb_reg_slave_32bit: RTL and testbench

APB-style register-bank responder sitting on the p_* bus driven by the UART-to-APB controller. It decodes p_ce/p_enable/p_we/p_addr and completes each transfer with a single p_rdy pulse after a programmable number of wait states. It holds a small register map: ID, scratch, control, status, free-running counter and W1C event flags. It gives the UART register-access path a defined far end for bring-up and test.

---
 rtl/pgr_apb_reg_slave_32bit.sv | 274 +++++++++++++++++++++++++++
 tb/tb_pgr_apb_reg_slave_32bit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgr_apb_reg_slave_32bit.sv
// ---------------------------------------------------------------------------
// pgr_apb_reg_slave_32bit
//
// APB-style register-bank responder for the p_* bus driven by the
// UART-to-APB controller. Each access (p_ce & p_enable) is latched and
// completed with a single p_rdy pulse after WAIT_CYC wait states. The
// responder then holds until the initiator drops p_enable/p_ce.
//
// Register map (decoded on p_addr[7:2]):
//   0x00 ID      RO   ID_VAL
//   0x04 SCRATCH RW   32 bit
//   0x08 CTRL    RW   bits [7:0], upper bits read 0
//   0x0C STATUS  RO   {16'h0, sts_in}
//   0x10 CNT     RO   free-running cycle counter
//   0x14 EVT     W1C  bits [7:0], set by evt_in (set wins over clear)
//   others: read 0, writes ignored
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   p_ce, p_enable  transfer select / access phase from initiator
//   p_addr, p_we    byte address (bits [1:0] ignored), write strobe
//   p_wdata         write data
//   p_rdy           one-cycle completion pulse
//   p_rdata         read data, valid only with p_rdy, 0 otherwise
//   sts_in          live status bits
//   evt_in          event pulses captured into EVT
//   ctrl_out        CTRL register contents
//   irq             registered OR of (EVT & CTRL)
//   p_slverr        (only with APB_SLV_ERR_EN) error flag in the p_rdy cycle
//
// Build option: define APB_SLV_ERR_EN to add p_slverr. Without it, accesses
// to unmapped addresses and writes to read-only registers complete silently.
// ---------------------------------------------------------------------------
module pgr_apb_reg_slave_32bit #(
    parameter int          AW       = 24,
    parameter int          DW       = 32,
    parameter int          WAIT_CYC = 2,
    parameter logic [31:0] ID_VAL   = 32'h5047_0001
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_ce,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    input  logic          p_enable,
    input  logic          p_we,
    output logic          p_rdy,
    output logic [DW-1:0] p_rdata,
    input  logic [15:0]   sts_in,
    input  logic [7:0]    evt_in,
    output logic [7:0]    ctrl_out,
    output logic          irq
`ifdef APB_SLV_ERR_EN
    ,
    output logic          p_slverr
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [5:0] A_ID      = 6'h00;
    localparam logic [5:0] A_SCRATCH = 6'h01;
    localparam logic [5:0] A_CTRL    = 6'h02;
    localparam logic [5:0] A_STATUS  = 6'h03;
    localparam logic [5:0] A_CNT     = 6'h04;
    localparam logic [5:0] A_EVT     = 6'h05;

    localparam logic [3:0] C_WAIT = 4'(WAIT_CYC);

    logic [1:0]    r_state;
    logic [3:0]    r_wcnt;
    logic [5:0]    r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic          r_rdy;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic [DW-1:0] r_scratch;
    logic [7:0]    r_ctrl;
    logic [7:0]    r_evt;
    logic [31:0]   r_cnt;
    logic          r_irq;

    logic [1:0]    w_nxt_state;
    logic          w_sel;
    logic          w_fire;
    logic [5:0]    w_x_addr;
    logic          w_x_we;
    logic [DW-1:0] w_x_wdata;
    logic [DW-1:0] w_rd_data;
    logic          w_mapped;
    logic          w_ro;
    logic          w_err;
    logic          w_wr_en;
    logic [7:0]    w_evt_clr;
    logic          w_unused_addr;

    // Address bits outside the decoded word index carry no meaning here.
    assign w_unused_addr = ^{p_addr[AW-1:8], p_addr[1:0]};

    // Transfer attributes: live bus while idle (zero-wait case completes
    // straight from IDLE), latched copy once the transfer is in flight.
    always_comb begin
        w_sel = p_ce & p_enable;
        if (r_state == S_IDLE) begin
            w_x_addr  = p_addr[7:2];
            w_x_we    = p_we;
            w_x_wdata = p_wdata;
        end else begin
            w_x_addr  = r_addr;
            w_x_we    = r_we;
            w_x_wdata = r_wdata;
        end
    end

    // Transfer sequencing: IDLE -> WAIT -> RESP -> HOLD -> IDLE.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sel) begin
                    if (C_WAIT == 4'd0) begin
                        w_nxt_state = S_RESP;
                    end else begin
                        w_nxt_state = S_WAIT;
                    end
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_WAIT: begin
                // An initiator abort beats completion even on the last wait cycle.
                if (!w_sel) begin
                    w_nxt_state = S_IDLE;
                end else if (r_wcnt <= 4'd1) begin
                    w_nxt_state = S_RESP;
                end else begin
                    w_nxt_state = S_WAIT;
                end
            end
            S_RESP: begin
                w_nxt_state = S_HOLD;
            end
            S_HOLD: begin
                if (!w_sel) begin
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_state = S_HOLD;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
        // RESP is only ever entered from IDLE or WAIT, so this is a
        // single-cycle strobe per completed transfer.
        w_fire = (w_nxt_state == S_RESP);
    end

    // Register read mux and access classification.
    always_comb begin
        w_rd_data = '0;
        w_mapped  = 1'b1;
        w_ro      = 1'b0;
        case (w_x_addr)
            A_ID: begin
                w_rd_data = ID_VAL;
                w_ro      = 1'b1;
            end
            A_SCRATCH: begin
                w_rd_data = r_scratch;
            end
            A_CTRL: begin
                w_rd_data = {24'h00_0000, r_ctrl};
            end
            A_STATUS: begin
                w_rd_data = {16'h0000, sts_in};
                w_ro      = 1'b1;
            end
            A_CNT: begin
                // Read data is registered, so return the count the
                // counter will hold during the RESP cycle.
                w_rd_data = r_cnt + 32'd1;
                w_ro      = 1'b1;
            end
            A_EVT: begin
                w_rd_data = {24'h00_0000, r_evt};
            end
            default: begin
                w_rd_data = '0;
                w_mapped  = 1'b0;
            end
        endcase
        w_err   = (~w_mapped) | (w_x_we & w_ro);
        // Writes to read-only or unmapped locations are dropped.
        w_wr_en = w_fire & w_x_we & ~w_err;
        if (w_wr_en && (w_x_addr == A_EVT)) begin
            w_evt_clr = w_x_wdata[7:0];
        end else begin
            w_evt_clr = 8'h00;
        end
    end

    // FSM, transfer latch, wait counter and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
            r_addr  <= 6'h00;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdy   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            if ((r_state == S_IDLE) && w_sel) begin
                r_addr  <= p_addr[7:2];
                r_we    <= p_we;
                r_wdata <= p_wdata;
                r_wcnt  <= C_WAIT;
            end else if ((r_state == S_WAIT) && (r_wcnt != 4'd0)) begin
                r_wcnt <= r_wcnt - 4'd1;
            end else begin
                r_wcnt <= r_wcnt;
            end
            r_rdy <= w_fire;
            r_err <= w_fire & w_err;
            if (w_fire && !w_x_we) begin
                r_rdata <= w_rd_data;
            end else begin
                r_rdata <= '0;
            end
        end
    end

    // Register bank, event capture, counter and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scratch <= '0;
            r_ctrl    <= 8'h00;
            r_evt     <= 8'h00;
            r_cnt     <= 32'h0000_0000;
            r_irq     <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_wr_en && (w_x_addr == A_SCRATCH)) begin
                r_scratch <= w_x_wdata;
            end else begin
                r_scratch <= r_scratch;
            end
            if (w_wr_en && (w_x_addr == A_CTRL)) begin
                r_ctrl <= w_x_wdata[7:0];
            end else begin
                r_ctrl <= r_ctrl;
            end
            // Clear first, then OR in new events so a same-cycle set wins.
            r_evt <= (r_evt & ~w_evt_clr) | evt_in;
            r_irq <= |(r_evt & r_ctrl);
        end
    end

    assign p_rdy    = r_rdy;
    assign p_rdata  = r_rdata;
    assign ctrl_out = r_ctrl;
    assign irq      = r_irq;
`ifdef APB_SLV_ERR_EN
    assign p_slverr = r_err;
`endif

endmodule

// File: tb/tb_pgr_apb_reg_slave_32bit.sv
module tb_pgr_apb_reg_slave_32bit;

    localparam int          WAITC = 2;
    localparam logic [31:0] IDV   = 32'h5047_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_ce;
    logic [23:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_enable;
    logic        p_we;
    logic        p_rdy;
    logic [31:0] p_rdata;
    logic [15:0] sts_in;
    logic [7:0]  evt_in;
    logic [7:0]  ctrl_out;
    logic        irq;
`ifdef APB_SLV_ERR_EN
    logic        p_slverr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_cnt;
    logic [31:0] m_scratch;
    logic [7:0]  m_ctrl;
    logic [7:0]  m_evt;

    always #5 clk = ~clk;

    // Reference cycle counter: cycles elapsed since reset released.
    always @(posedge clk) begin
        if (rst) m_cnt <= 32'd0;
        else     m_cnt <= m_cnt + 32'd1;
    end

    pgr_apb_reg_slave_32bit #(
        .AW(24), .DW(32), .WAIT_CYC(WAITC), .ID_VAL(IDV)
    ) dut (
        .clk(clk), .rst(rst), .p_ce(p_ce), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_enable(p_enable), .p_we(p_we), .p_rdy(p_rdy), .p_rdata(p_rdata),
        .sts_in(sts_in), .evt_in(evt_in), .ctrl_out(ctrl_out), .irq(irq)
`ifdef APB_SLV_ERR_EN
        , .p_slverr(p_slverr)
`endif
    );

    function automatic logic [31:0] model_read(input logic [23:0] a, input logic [31:0] cnt_now);
        int w;
        w = int'(a[7:2]);
        if (w == 0)      return IDV;
        else if (w == 1) return m_scratch;
        else if (w == 2) return {24'd0, m_ctrl};
        else if (w == 3) return {16'd0, sts_in};
        else if (w == 4) return cnt_now;
        else if (w == 5) return {24'd0, m_evt};
        else             return 32'd0;
    endfunction

    function automatic void model_write(input logic [23:0] a, input logic [31:0] d);
        int w;
        w = int'(a[7:2]);
        if (w == 1)      m_scratch = d;
        else if (w == 2) m_ctrl = d[7:0];
        else if (w == 5) m_evt = (m_evt & ~d[7:0]) | evt_in;
    endfunction

    function automatic logic model_err(input logic [23:0] a, input logic we);
        int w;
        w = int'(a[7:2]);
        return (w > 5) || (we && (w == 0 || w == 3 || w == 4));
    endfunction

    // Drive one transfer; report data, latency (cycles to p_rdy), extra
    // p_rdy pulses seen while holding, error flag and counter at p_rdy.
    task automatic xfer(input logic [23:0] a, input logic we, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output int lat,
                        output int extra, output logic err, output logic [31:0] cnt_at);
        rd = 32'd0; lat = -1; extra = 0; err = 1'b0; cnt_at = 32'd0;
        @(negedge clk);
        p_ce = 1'b1; p_enable = 1'b1; p_addr = a; p_we = we; p_wdata = wd;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (p_rdy === 1'b1) begin
                lat = c; rd = p_rdata; cnt_at = m_cnt;
`ifdef APB_SLV_ERR_EN
                err = p_slverr;
`endif
                evt_in = 8'h00;
            end else begin
                // Bus changes after the access is latched must be ignored.
                p_addr  = 24'($urandom);
                p_wdata = $urandom;
                p_we    = ~we;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (p_rdy === 1'b1) extra++;
        end
        p_ce = 1'b0; p_enable = 1'b0;
        @(negedge clk);
        if (p_rdy === 1'b1) extra++;
    endtask

    task automatic test_reset();
        logic [31:0] rd, ca; int lat, ex; logic er;
        rst = 1'b1; p_ce = 1'b0; p_enable = 1'b0; p_we = 1'b0;
        p_addr = 24'($urandom); p_wdata = $urandom; sts_in = 16'h0; evt_in = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (p_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got=%b want=0", p_rdy); end
        n_cmp++; if (p_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got=%h want=0", p_rdata); end
        n_cmp++; if (ctrl_out !== 8'd0) begin n_bad++; $display("FAIL reset_ctrl got=%h want=0", ctrl_out); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        rst = 1'b0;
        m_scratch = 32'd0; m_ctrl = 8'd0; m_evt = 8'd0;
        xfer(24'h000004, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_scratch got=%h want=0", rd); end
        xfer(24'h000010, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== ca) begin n_bad++; $display("FAIL reset_cnt got=%h want=%h", rd, ca); end
    endtask

    task automatic test_id_read();
        logic [31:0] rd, ca; int lat, ex; logic er;
        xfer(24'hAB3C00, 1'b0, 32'd0, 2, rd, lat, ex, er, ca);
        n_cmp++; if (lat != WAITC + 1) begin n_bad++; $display("FAIL id_latency got=%0d want=%0d", lat, WAITC + 1); end
        n_cmp++; if (rd !== IDV) begin n_bad++; $display("FAIL id_rdata got=%h want=%h", rd, IDV); end
        n_cmp++; if (ex != 0) begin n_bad++; $display("FAIL id_single_pulse got=%0d extra want=0", ex); end
    endtask

    task automatic test_scratch_ctrl();
        logic [31:0] rd, ca; int lat, ex; logic er;
        xfer(24'h000004, 1'b1, 32'hA5A5_1234, 0, rd, lat, ex, er, ca);
        model_write(24'h000004, 32'hA5A5_1234);
        xfer(24'h000004, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== 32'hA5A5_1234) begin n_bad++; $display("FAIL scratch_rb got=%h want=A5A51234", rd); end
        xfer(24'h000008, 1'b1, 32'hFFFF_FF3C, 0, rd, lat, ex, er, ca);
        model_write(24'h000008, 32'hFFFF_FF3C);
        n_cmp++; if (ctrl_out !== 8'h3C) begin n_bad++; $display("FAIL ctrl_out got=%h want=3c", ctrl_out); end
        xfer(24'h000008, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== 32'h0000_003C) begin n_bad++; $display("FAIL ctrl_rb got=%h want=0000003c", rd); end
    endtask

    task automatic test_evt();
        logic [31:0] rd, ca; int lat, ex; logic er;
        xfer(24'h000008, 1'b1, 32'h0000_0004, 0, rd, lat, ex, er, ca);
        model_write(24'h000008, 32'h0000_0004);
        @(negedge clk); evt_in = 8'h05;
        @(negedge clk); evt_in = 8'h00; m_evt = m_evt | 8'h05;
        repeat (2) @(negedge clk);
        n_cmp++; if (irq !== (|(m_evt & m_ctrl))) begin n_bad++; $display("FAIL evt_irq_set got=%b want=%b", irq, |(m_evt & m_ctrl)); end
        xfer(24'h000014, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== {24'd0, m_evt}) begin n_bad++; $display("FAIL evt_rd got=%h want=%h", rd, {24'd0, m_evt}); end
        xfer(24'h000014, 1'b1, 32'h0000_0004, 0, rd, lat, ex, er, ca);
        model_write(24'h000014, 32'h0000_0004);
        repeat (2) @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL evt_irq_clr got=%b want=0", irq); end
        xfer(24'h000014, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL evt_w1c got=%h want=00000001", rd); end
        // Event on bit 0 held through the clearing write: set must win.
        evt_in = 8'h01;
        xfer(24'h000014, 1'b1, 32'h0000_0001, 0, rd, lat, ex, er, ca);
        xfer(24'h000014, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== 32'h0000_0001) begin n_bad++; $display("FAIL evt_set_wins got=%h want=00000001", rd); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, ca; int lat, ex; logic er;
        xfer(24'h000040, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL unmapped_rd got=%h want=0", rd); end
`ifdef APB_SLV_ERR_EN
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL unmapped_err got=%b want=1", er); end
`endif
        xfer(24'h000000, 1'b1, 32'hDEAD_BEEF, 0, rd, lat, ex, er, ca);
`ifdef APB_SLV_ERR_EN
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL id_wr_err got=%b want=1", er); end
`endif
        xfer(24'h000000, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== IDV) begin n_bad++; $display("FAIL id_after_wr got=%h want=%h", rd, IDV); end
    endtask

    task automatic test_hold();
        logic [31:0] rd, ca; int lat, ex; logic er;
        xfer(24'h000004, 1'b0, 32'd0, 5, rd, lat, ex, er, ca);
        n_cmp++; if (ex != 0) begin n_bad++; $display("FAIL hold_no_repeat got=%0d extra want=0", ex); end
        n_cmp++; if (rd !== m_scratch) begin n_bad++; $display("FAIL hold_rd got=%h want=%h", rd, m_scratch); end
    endtask

    task automatic test_abort();
        logic [31:0] rd, ca; int lat, ex, seen; logic er;
        seen = 0;
        @(negedge clk);
        p_ce = 1'b1; p_enable = 1'b1; p_we = 1'b1; p_addr = 24'h000004; p_wdata = 32'h1357_9BDF;
        @(negedge clk);
        if (p_rdy === 1'b1) seen++;
        p_enable = 1'b0;
        repeat (6) begin @(negedge clk); if (p_rdy === 1'b1) seen++; end
        p_ce = 1'b0;
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_rdy got=%0d pulses want=0", seen); end
        xfer(24'h000004, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== m_scratch) begin n_bad++; $display("FAIL abort_scratch got=%h want=%h", rd, m_scratch); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] rd, ca; int lat, ex, seen; logic er;
        seen = 0;
        @(negedge clk);
        p_ce = 1'b1; p_enable = 1'b1; p_we = 1'b1; p_addr = 24'h000004; p_wdata = 32'h2468_ACE0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (p_rdy === 1'b1) seen++;
        n_cmp++; if (ctrl_out !== 8'd0) begin n_bad++; $display("FAIL rst_mid_ctrl got=%h want=0", ctrl_out); end
        rst = 1'b0; p_ce = 1'b0; p_enable = 1'b0;
        m_scratch = 32'd0; m_ctrl = 8'd0; m_evt = 8'd0;
        repeat (5) begin @(negedge clk); if (p_rdy === 1'b1) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_mid_rdy got=%0d pulses want=0", seen); end
        xfer(24'h000004, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL rst_mid_scratch got=%h want=0", rd); end
        xfer(24'h000014, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL rst_mid_evt got=%h want=0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, ca, d0, d1; int lat, ex; logic er;
        d0 = $urandom; d1 = $urandom;
        xfer(24'h000004, 1'b1, d0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (lat != WAITC + 1 || ex != 0) begin n_bad++; $display("FAIL b2b_first got=lat%0d/ex%0d want=lat%0d/ex0", lat, ex, WAITC + 1); end
        model_write(24'h000004, d0);
        xfer(24'h000008, 1'b1, d1, 0, rd, lat, ex, er, ca);
        n_cmp++; if (lat != WAITC + 1 || ex != 0) begin n_bad++; $display("FAIL b2b_second got=lat%0d/ex%0d want=lat%0d/ex0", lat, ex, WAITC + 1); end
        model_write(24'h000008, d1);
        xfer(24'h000004, 1'b0, 32'd0, 0, rd, lat, ex, er, ca);
        n_cmp++; if (rd !== m_scratch) begin n_bad++; $display("FAIL b2b_scratch got=%h want=%h", rd, m_scratch); end
    endtask

    task automatic test_random(input int n);
        logic [31:0] rd, ca, wd, exp; logic [23:0] a; logic we; int lat, ex; logic er;
        for (int i = 0; i < n; i++) begin
            a = 24'($urandom);
            a[7:2] = 6'($urandom_range(0, 9));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            sts_in = 16'($urandom);
            xfer(a, we, wd, int'($urandom_range(0, 2)), rd, lat, ex, er, ca);
            n_cmp++; if (lat != WAITC + 1) begin n_bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, WAITC + 1); end
            n_cmp++; if (ex != 0) begin n_bad++; $display("FAIL rand_extra[%0d] got=%0d want=0", i, ex); end
`ifdef APB_SLV_ERR_EN
            n_cmp++; if (er !== model_err(a, we)) begin n_bad++; $display("FAIL rand_err[%0d] got=%b want=%b", i, er, model_err(a, we)); end
`endif
            if (we) begin
                model_write(a, wd);
            end else begin
                exp = model_read(a, ca);
                n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL rand_rd[%0d] a=%h got=%h want=%h", i, a, rd, exp); end
            end
            repeat (2) @(negedge clk);
            n_cmp++; if (ctrl_out !== m_ctrl) begin n_bad++; $display("FAIL rand_ctrl[%0d] got=%h want=%h", i, ctrl_out, m_ctrl); end
            n_cmp++; if (irq !== (|(m_evt & m_ctrl))) begin n_bad++; $display("FAIL rand_irq[%0d] got=%b want=%b", i, irq, |(m_evt & m_ctrl)); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_id_read();
        test_scratch_ctrl();
        test_evt();
        test_unmapped();
        test_hold();
        test_abort();
        test_back_to_back();
        test_random(60);
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
